// File: rtl/cc_cond_unit.sv
// Condition-code register and branch/cmov condition evaluation for the execute stage (optional stats: CC_PERF_CNT_EN).
// Latency: e_Cnd/e_mispredict combinational from registered CC; CC and M_Cnd update one edge later.
// Backpressure: M_stall holds M_Cnd, M_bubble clears it (wins over stall); the CC write ignores both.
module cc_cond_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] E_icode,
   input  logic [3:0] E_ifun,
   input  logic       alu_zf,
   input  logic       alu_sf,
   input  logic       alu_of,
   input  logic       m_exc,
   input  logic       W_exc,
   input  logic       M_stall,
   input  logic       M_bubble,
   output logic       cc_zf,
   output logic       cc_sf,
   output logic       cc_of,
   output logic       e_Cnd,
   output logic       e_mispredict,
   output logic       M_Cnd
`ifdef CC_PERF_CNT_EN
   ,
   output logic [31:0] taken_cnt,
   output logic [31:0] ntaken_cnt
`endif
);

   localparam logic [3:0] ICODE_CMOV = 4'd2;
   localparam logic [3:0] ICODE_OPQ  = 4'd6;
   localparam logic [3:0] ICODE_JXX  = 4'd7;

   // An OPq only commits its flags when no older instruction is raising an exception.
   logic set_cc;
   assign set_cc = (E_icode == ICODE_OPQ) && !m_exc && !W_exc;

   // Condition-code register; the reset value reflects a zero result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_zf <= 1'b1;
         cc_sf <= 1'b0;
         cc_of <= 1'b0;
      end else if (set_cc) begin
         cc_zf <= alu_zf;
         cc_sf <= alu_sf;
         cc_of <= alu_of;
      end
   end

   // Condition evaluated from the registered flags only, so an OPq's own flags affect later instructions.
   logic lt;
   logic cond;
   always_comb begin
      lt   = cc_sf ^ cc_of;
      cond = 1'b0;
      case (E_ifun)
         4'd0:    cond = 1'b1;
         4'd1:    cond = lt | cc_zf;
         4'd2:    cond = lt;
         4'd3:    cond = cc_zf;
         4'd4:    cond = ~cc_zf;
         4'd5:    cond = ~lt;
         4'd6:    cond = ~lt & ~cc_zf;
         default: cond = 1'b0;
      endcase
      e_Cnd = cond && ((E_icode == ICODE_CMOV) || (E_icode == ICODE_JXX));
   end

   // Jumps are predicted taken, so a jXX whose condition fails was mispredicted.
   assign e_mispredict = (E_icode == ICODE_JXX) && !e_Cnd;

   // E-to-M pipeline register for the condition result; bubble beats stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         M_Cnd <= 1'b0;
      end else if (M_bubble) begin
         M_Cnd <= 1'b0;
      end else if (!M_stall) begin
         M_Cnd <= e_Cnd;
      end
   end

`ifdef CC_PERF_CNT_EN
   // Branch statistics: count each jXX as it advances into memory; counters wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_cnt  <= '0;
         ntaken_cnt <= '0;
      end else if ((E_icode == ICODE_JXX) && !M_stall && !M_bubble) begin
         if (e_Cnd) begin
            taken_cnt <= taken_cnt + 32'd1;
         end else begin
            ntaken_cnt <= ntaken_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed bench for cc_cond_unit: hand-computed expectations for reset, CC load, gating, condition table, pipeline control.
// Latency: checks combinational outputs immediately, registered outputs 1 time unit after the edge.
// Backpressure: exercises M_stall/M_bubble on the M_Cnd register.
`timescale 1ns/1ps
module tb_cc_cond_unit;

   logic       clk;
   logic       rst_n;
   logic [3:0] E_icode;
   logic [3:0] E_ifun;
   logic       alu_zf, alu_sf, alu_of;
   logic       m_exc, W_exc;
   logic       M_stall, M_bubble;
   logic       cc_zf, cc_sf, cc_of;
   logic       e_Cnd, e_mispredict, M_Cnd;
`ifdef CC_PERF_CNT_EN
   logic [31:0] taken_cnt, ntaken_cnt;
`endif

   int total;
   int bad;

   cc_cond_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .E_icode      (E_icode),
      .E_ifun       (E_ifun),
      .alu_zf       (alu_zf),
      .alu_sf       (alu_sf),
      .alu_of       (alu_of),
      .m_exc        (m_exc),
      .W_exc        (W_exc),
      .M_stall      (M_stall),
      .M_bubble     (M_bubble),
      .cc_zf        (cc_zf),
      .cc_sf        (cc_sf),
      .cc_of        (cc_of),
      .e_Cnd        (e_Cnd),
      .e_mispredict (e_mispredict),
      .M_Cnd        (M_Cnd)
`ifdef CC_PERF_CNT_EN
      ,
      .taken_cnt    (taken_cnt),
      .ntaken_cnt   (ntaken_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: count it, report a mismatch.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cc(input string tag, input logic zf, input logic sf, input logic of);
      chk({tag, "_cc"}, {29'd0, cc_zf, cc_sf, cc_of}, {29'd0, zf, sf, of});
   endtask

   // Expected e_Cnd for cc={1,1,1}, E_icode=2, E_ifun=0..7.
   logic [7:0] tbl_exp;

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      E_icode = 4'd0; E_ifun = 4'd0;
      alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b0;
      m_exc = 1'b0; W_exc = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
      repeat (2) step();

      // Reset values
      chk_cc("rst", 1'b1, 1'b0, 1'b0);
      chk("rst_mcnd", {31'd0, M_Cnd}, 32'd0);
      E_icode = 4'd7; E_ifun = 4'd3; #1;
      chk("rst_je_cnd", {31'd0, e_Cnd}, 32'd1);
      chk("rst_je_misp", {31'd0, e_mispredict}, 32'd0);
`ifdef CC_PERF_CNT_EN
      chk("rst_taken", taken_cnt, 32'd0);
      chk("rst_ntaken", ntaken_cnt, 32'd0);
`endif
      E_icode = 4'd0;
      rst_n = 1'b1;

      // CC load from an OPq, first edge after release
      E_icode = 4'd6; alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b0;
      step();
      chk_cc("load", 1'b0, 1'b1, 1'b0);
      E_icode = 4'd7; E_ifun = 4'd2; #1;
      chk("jl_cnd", {31'd0, e_Cnd}, 32'd1);
      chk("jl_misp", {31'd0, e_mispredict}, 32'd0);
      E_ifun = 4'd5; #1;
      chk("jge_cnd", {31'd0, e_Cnd}, 32'd0);
      chk("jge_misp", {31'd0, e_mispredict}, 32'd1);

      // Exception gating: first set all flags, then try to clear zf under exceptions
      E_icode = 4'd6; alu_zf = 1'b1; alu_sf = 1'b1; alu_of = 1'b1;
      step();
      chk_cc("load111", 1'b1, 1'b1, 1'b1);
      alu_zf = 1'b0; m_exc = 1'b1;
      step();
      chk_cc("mexc", 1'b1, 1'b1, 1'b1);
      m_exc = 1'b0; W_exc = 1'b1;
      step();
      chk_cc("wexc", 1'b1, 1'b1, 1'b1);
      W_exc = 1'b0; E_icode = 4'd0;
      step();
      chk_cc("nonop", 1'b1, 1'b1, 1'b1);

      // Condition table with cc={1,1,1}
      tbl_exp = 8'b0010_1011; // bit i = expected e_Cnd for ifun i
      E_icode = 4'd2;
      for (int i = 0; i < 8; i++) begin
         E_ifun = 4'(i); #1;
         chk($sformatf("tbl_ifun%0d", i), {31'd0, e_Cnd}, {31'd0, tbl_exp[i]});
      end
      E_ifun = 4'd15; #1;
      chk("tbl_ifun15", {31'd0, e_Cnd}, 32'd0);
      E_icode = 4'd0; E_ifun = 4'd0; #1;
      chk("icode0", {31'd0, e_Cnd}, 32'd0);
      chk("icode0_misp", {31'd0, e_mispredict}, 32'd0);

      // Pipeline control on M_Cnd
      M_bubble = 1'b1; step();
      chk("mcnd_bub", {31'd0, M_Cnd}, 32'd0);
      E_icode = 4'd2; E_ifun = 4'd0; M_bubble = 1'b0; M_stall = 1'b1; step();
      chk("mcnd_stall", {31'd0, M_Cnd}, 32'd0);
      M_bubble = 1'b1; step();
      chk("mcnd_stall_bub", {31'd0, M_Cnd}, 32'd0);
      M_stall = 1'b0; M_bubble = 1'b0; step();
      chk("mcnd_load", {31'd0, M_Cnd}, 32'd1);
      E_icode = 4'd0; M_stall = 1'b1; step();
      chk("mcnd_hold1", {31'd0, M_Cnd}, 32'd1);
      M_stall = 1'b0; M_bubble = 1'b1; step();
      chk("mcnd_bub2", {31'd0, M_Cnd}, 32'd0);

      // CC write ignores stall/bubble
      E_icode = 4'd6; alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b1;
      M_stall = 1'b1; M_bubble = 1'b1; step();
      chk_cc("stall_cc", 1'b0, 1'b0, 1'b1);
      M_stall = 1'b0; M_bubble = 1'b0;

      // Load M_Cnd=1, then reset mid-cycle with an OPq pending
      E_icode = 4'd2; E_ifun = 4'd4; step();
      chk("pre_rst_mcnd", {31'd0, M_Cnd}, 32'd1);
      E_icode = 4'd6; alu_zf = 1'b1; alu_sf = 1'b1; alu_of = 1'b0;
      #2 rst_n = 1'b0; #1;
      chk_cc("async_rst", 1'b1, 1'b0, 1'b0);
      chk("async_rst_mcnd", {31'd0, M_Cnd}, 32'd0);
      step();
      chk_cc("rst_edge", 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      chk_cc("post_rst", 1'b1, 1'b1, 1'b0);

`ifdef CC_PERF_CNT_EN
      // Branch statistics: one taken, one not taken, one stalled
      E_icode = 4'd7; E_ifun = 4'd0; step();
      chk("cnt_taken", taken_cnt, 32'd1);
      E_ifun = 4'd15; step();
      chk("cnt_ntaken", ntaken_cnt, 32'd1);
      M_stall = 1'b1; step();
      chk("cnt_stall_t", taken_cnt, 32'd1);
      chk("cnt_stall_n", ntaken_cnt, 32'd1);
      M_stall = 1'b0; E_icode = 4'd0;
      #2 rst_n = 1'b0; #1;
      chk("cnt_rst_t", taken_cnt, 32'd0);
      chk("cnt_rst_n", ntaken_cnt, 32'd0);
      rst_n = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cc_cond_unit.md
CC_COND_UNIT -- requirements
Module: cc_cond_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports are listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 E_icode  input  4  execute-stage icode: OPq=6, jXX=7, cmovXX=2.
REQ-005 E_ifun  input  4  execute-stage function code, which selects the condition.
REQ-006 alu_zf, alu_sf, alu_of  input  1 each  flags from the ALU result of the current execute-stage instruction.
REQ-007 m_exc, W_exc  input  1 each  exception present in the memory and writeback stages.
REQ-008 M_stall, M_bubble  input  1 each  pipeline control for the E-to-M register.
REQ-009 cc_zf, cc_sf, cc_of  output  1 each  architectural condition-code register.
REQ-010 e_Cnd  output  1  combinational condition result for the execute-stage instruction.
REQ-011 e_mispredict  output  1  combinational taken-predicted jXX resolved not-taken.
REQ-012 M_Cnd  output  1  registered e_Cnd in the memory stage.
REQ-013 taken_cnt, ntaken_cnt  output  32 each  branch statistics; present only with CC_PERF_CNT_EN.

Function
REQ-014 set_cc SHALL be defined as (E_icode==6) AND NOT m_exc AND NOT W_exc.
REQ-015 On a rising edge with set_cc=1, {cc_zf,cc_sf,cc_of} SHALL load {alu_zf,alu_sf,alu_of}; otherwise the register holds its value.
REQ-016 e_Cnd SHALL be evaluated from the registered CC, never from the alu_* inputs, so the flags of the current OPq affect only the instructions after it.
REQ-017 e_Cnd by E_ifun: 0=1; 1=(sf^of)|zf; 2=sf^of; 3=zf; 4=~zf; 5=~(sf^of); 6=~(sf^of)&~zf; 7..15=0.
REQ-018 e_Cnd SHALL be 0 when E_icode is neither 2 nor 7.
REQ-019 e_mispredict SHALL equal (E_icode==7) AND NOT e_Cnd.
REQ-020 M_Cnd update: M_bubble=1 loads 0 (bubble has priority over stall); else M_stall=1 holds; else loads e_Cnd.
REQ-021 set_cc SHALL NOT be gated by M_stall or M_bubble; the CC write depends only on REQ-014.
REQ-022 Latency: the CC update is visible one cycle after the OPq is in execute; M_Cnd lags e_Cnd by one cycle.

Reset
REQ-023 While rst_n=0, asynchronously: cc_zf=1, cc_sf=0, cc_of=0, M_Cnd=0, taken_cnt=0, ntaken_cnt=0.
REQ-024 Reset asserted mid-operation SHALL discard any pending CC or M_Cnd update on that edge.
REQ-025 After release, the first rising edge behaves per REQ-015/REQ-020 with no extra wait state.

Configuration
REQ-026 Macro CC_PERF_CNT_EN: when defined, taken_cnt and ntaken_cnt ports and counters SHALL exist.
REQ-027 With CC_PERF_CNT_EN, on each edge with E_icode==7 and M_stall=0 and M_bubble=0, taken_cnt increments if e_Cnd=1, else ntaken_cnt increments.
REQ-028 Counters SHALL wrap from 0xFFFFFFFF to 0 silently.
REQ-029 Without CC_PERF_CNT_EN, the ports and counter logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-030 Reset: rst_n=0 -> cc={zf=1,sf=0,of=0}, M_Cnd=0; E_icode=7, E_ifun=3 -> e_Cnd=1, e_mispredict=0.
REQ-031 CC load: E_icode=6, alu flags zf=0,sf=1,of=0, one edge -> cc_sf=1; next E_icode=7, E_ifun=2 -> e_Cnd=1; E_ifun=5 -> e_Cnd=0, e_mispredict=1.
REQ-032 Exception gating: E_icode=6, alu_zf=0, m_exc=1, one edge -> cc_zf stays 1; repeat with W_exc=1 -> cc_zf stays 1.
REQ-033 Condition table: cc={zf=1,sf=1,of=1}, sweep E_icode=2, E_ifun=0..7 -> e_Cnd=1,1,0,1,0,1,0,0.
REQ-034 Pipeline control: e_Cnd=1 with M_stall=1 -> M_Cnd holds 0; M_stall=1 and M_bubble=1 -> M_Cnd=0; both 0 -> M_Cnd=1 after one edge.
REQ-035 Counters (CC_PERF_CNT_EN): preload taken_cnt=0xFFFFFFFF, one taken jXX -> 0; rst_n pulse mid-sequence -> both counters 0.
